// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle MIPS core: generates the
// architectural update enable, decodes halt/display syscalls, keeps statistics.
module cpu_run_ctrl #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter logic [31:0] SHOW_CODE = 32'd34,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             step_mode,
    input  logic             syscall,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             branch_taken,
    output logic             cpu_en,
    output logic             halted,
    output logic [31:0]      total_cycle,
    output logic [CNT_W-1:0] unconditional,
    output logic [CNT_W-1:0] conditional,
    output logic [CNT_W-1:0] conditionalsucces,
    output logic [31:0]      syscall_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   go_q;
    logic   go_rise;
    logic   hc;
    logic   show;
    logic   fire;

    assign go_rise = go & ~go_q;
    assign hc      = syscall & (v0 == HALT_CODE);
    assign show    = syscall & (v0 == SHOW_CODE);
    // The halting syscall never retires, so the PC stays parked on it.
    assign cpu_en  = fire & ~hc;

    always_comb begin
        state_nx = state;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                if (go_rise) state_nx = step_mode ? STEP : RUN;
            end
            RUN: begin
                fire = 1'b1;
                if (hc)             state_nx = HALT;
                else if (step_mode) state_nx = STEP;
            end
            STEP: begin
                fire = go_rise & step_mode;
                if (go_rise & ~step_mode) state_nx = RUN;
                else if (fire & hc)       state_nx = HALT;
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            go_q   <= 1'b1;
            halted <= 1'b0;
        end else begin
            state  <= state_nx;
            go_q   <= go;
            halted <= (state_nx == HALT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            total_cycle       <= '0;
            unconditional     <= '0;
            conditional       <= '0;
            conditionalsucces <= '0;
            syscall_out       <= '0;
        end else if (cpu_en) begin
            total_cycle <= total_cycle + 32'd1;
            if (is_jump)                  unconditional     <= unconditional + 1'b1;
            if (is_branch)                conditional       <= conditional + 1'b1;
            if (is_branch & branch_taken) conditionalsucces <= conditionalsucces + 1'b1;
            if (show)                     syscall_out       <= a0;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        step_mode = 1'b0;
    logic        syscall = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        is_jump = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        cpu_en;
    logic        halted;
    logic [31:0] total_cycle;
    logic [15:0] unconditional;
    logic [15:0] conditional;
    logic [15:0] conditionalsucces;
    logic [31:0] syscall_out;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.HALT_CODE(32'd10), .SHOW_CODE(32'd34), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .go(go), .step_mode(step_mode),
        .syscall(syscall), .v0(v0), .a0(a0),
        .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken),
        .cpu_en(cpu_en), .halted(halted), .total_cycle(total_cycle),
        .unconditional(unconditional), .conditional(conditional),
        .conditionalsucces(conditionalsucces), .syscall_out(syscall_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset, release, then press go to leave IDLE into RUN or STEP.
    task automatic start_core(input logic sm);
        rst = 1'b0; go = 1'b0; step_mode = sm;
        syscall = 1'b0; is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        go = 1'b1;
        tick;
        go = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; go = 1'b1;
        tick; tick;
        rst = 1'b1;
        repeat (3) begin
            #1;
            checks++;
            if (cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
            tick;
        end
        checks++;
        if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++;
        if (total_cycle !== 32'd0 || unconditional !== 16'd0 || conditional !== 16'd0 ||
            conditionalsucces !== 16'd0 || syscall_out !== 32'd0) begin
            fails++;
            $display("FAIL reset_counters got %0d %0d %0d %0d %h want all 0",
                     total_cycle, unconditional, conditional, conditionalsucces, syscall_out);
        end
        go = 1'b0;
        tick;
        go = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin fails++; $display("FAIL start_press_cycle got %b want 0", cpu_en); end
        tick;
        #1;
        checks++;
        if (cpu_en !== 1'b1) begin fails++; $display("FAIL run_first_cycle got %b want 1", cpu_en); end
    endtask

    // Continues from RUN entered in test_reset, counters at 0.
    task automatic test_run_stats;
        for (int i = 0; i < 100; i++) begin
            is_jump      = (i < 20);
            is_branch    = (i >= 20 && i < 50);
            branch_taken = (i >= 20 && i < 32);
            #1;
            checks++;
            if (cpu_en !== 1'b1) begin fails++; $display("FAIL run_en cycle %0d got %b want 1", i, cpu_en); end
            tick;
        end
        is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        checks++;
        if (total_cycle !== 32'd100) begin fails++; $display("FAIL total_cycle got %0d want 100", total_cycle); end
        checks++;
        if (unconditional !== 16'd20) begin fails++; $display("FAIL unconditional got %0d want 20", unconditional); end
        checks++;
        if (conditional !== 16'd30) begin fails++; $display("FAIL conditional got %0d want 30", conditional); end
        checks++;
        if (conditionalsucces !== 16'd12) begin fails++; $display("FAIL conditionalsucces got %0d want 12", conditionalsucces); end
    endtask

    task automatic test_syscall_halt;
        syscall = 1'b1; v0 = 32'd34; a0 = 32'hDEADBEEF;
        #1;
        checks++;
        if (cpu_en !== 1'b1) begin fails++; $display("FAIL show_en got %b want 1", cpu_en); end
        tick;
        v0 = 32'd10; a0 = 32'h12345678;
        checks++;
        if (syscall_out !== 32'hDEADBEEF) begin fails++; $display("FAIL syscall_out got %h want deadbeef", syscall_out); end
        checks++;
        if (total_cycle !== 32'd101) begin fails++; $display("FAIL show_total got %0d want 101", total_cycle); end
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin fails++; $display("FAIL halt_en got %b want 0", cpu_en); end
        checks++;
        if (halted !== 1'b0) begin fails++; $display("FAIL halted_early got %b want 0", halted); end
        tick;
        syscall = 1'b0; v0 = 32'd0;
        checks++;
        if (halted !== 1'b1) begin fails++; $display("FAIL halted got %b want 1", halted); end
        for (int p = 0; p < 3; p++) begin
            go = 1'b0; tick;
            go = 1'b1; #1;
            checks++;
            if (cpu_en !== 1'b0) begin fails++; $display("FAIL halt_go_en press %0d got %b want 0", p, cpu_en); end
            tick;
        end
        go = 1'b0;
        checks++;
        if (total_cycle !== 32'd101 || syscall_out !== 32'hDEADBEEF || halted !== 1'b1) begin
            fails++;
            $display("FAIL halt_frozen got total %0d out %h halted %b want 101 deadbeef 1",
                     total_cycle, syscall_out, halted);
        end
    endtask

    task automatic test_step;
        start_core(1'b1);
        tick;
        for (int p = 0; p < 3; p++) begin
            go = 1'b1;
            for (int h = 0; h < 5; h++) begin
                #1;
                checks++;
                if (cpu_en !== (h == 0)) begin
                    fails++;
                    $display("FAIL step_pulse press %0d cycle %0d got %b want %b", p, h, cpu_en, (h == 0));
                end
                tick;
            end
            go = 1'b0;
            tick; tick;
        end
        checks++;
        if (total_cycle !== 32'd3) begin fails++; $display("FAIL step_total got %0d want 3", total_cycle); end
        step_mode = 1'b0; go = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin fails++; $display("FAIL step_to_run_press got %b want 0", cpu_en); end
        tick;
        checks++;
        if (total_cycle !== 32'd3) begin fails++; $display("FAIL step_to_run_total got %0d want 3", total_cycle); end
        #1;
        checks++;
        if (cpu_en !== 1'b1) begin fails++; $display("FAIL run_after_step got %b want 1", cpu_en); end
        tick;
        step_mode = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b1) begin fails++; $display("FAIL step_rise_in_run got %b want 1", cpu_en); end
        tick;
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin fails++; $display("FAIL step_after_run got %b want 0", cpu_en); end
        checks++;
        if (total_cycle !== 32'd5) begin fails++; $display("FAIL step_rise_total got %0d want 5", total_cycle); end
        go = 1'b0;
    endtask

    task automatic test_wrap_reset;
        start_core(1'b0);
        is_jump = 1'b1;
        repeat (65535) tick;
        checks++;
        if (unconditional !== 16'hFFFF) begin fails++; $display("FAIL uncond_preload got %h want ffff", unconditional); end
        tick;
        checks++;
        if (unconditional !== 16'h0000) begin fails++; $display("FAIL uncond_wrap got %h want 0000", unconditional); end
        checks++;
        if (total_cycle !== 32'd65536) begin fails++; $display("FAIL wrap_total got %0d want 65536", total_cycle); end
        syscall = 1'b1; v0 = 32'd34; a0 = 32'hCAFEF00D;
        rst = 1'b0;
        tick;
        rst = 1'b1; syscall = 1'b0; is_jump = 1'b0;
        checks++;
        if (total_cycle !== 32'd0 || unconditional !== 16'd0 || conditional !== 16'd0 ||
            conditionalsucces !== 16'd0 || syscall_out !== 32'd0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset got %0d %0d %0d %0d %h %b want all 0",
                     total_cycle, unconditional, conditional, conditionalsucces, syscall_out, halted);
        end
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin fails++; $display("FAIL midrun_reset_idle got %b want 0", cpu_en); end
        tick;
        checks++;
        if (total_cycle !== 32'd0) begin fails++; $display("FAIL idle_after_reset got %0d want 0", total_cycle); end
    endtask

    initial begin
        test_reset;
        test_run_stats;
        test_syscall_halt;
        test_step;
        test_wrap_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt sequencer for the single-cycle MIPS core. It produces the clock-enable `cpu_en` that gates every architectural state update: PC load, RegisterFile write and DataMemo write. It decodes the halt and display syscalls. It keeps the cycle and branch statistics shown by `show_signal`. It sits between the controler/NPC decode outputs and the state elements, clocked by `clk_run`.

## Interface
Parameters:
- `HALT_CODE`, 32'd10: `$v0` value that makes a syscall halt the core.
- `SHOW_CODE`, 32'd34: `$v0` value that makes a syscall latch `$a0` for display.
- `CNT_W`, 16: width of the three branch statistic counters.

Ports:
- `clk`  in  1  core clock (`clk_run`).
- `rst`  in  1  reset; synchronous, active-low.
- `go`  in  1  start/step button level, already debounced; the block edge-detects it internally.
- `step_mode`  in  1  1 = single-step, 0 = free run.
- `syscall`  in  1  current instruction is SYSCALL (controler).
- `v0`  in  32  RegisterFile port a while `syscall`=1 (`$2`).
- `a0`  in  32  RegisterFile port b while `syscall`=1 (`$4`).
- `is_jump`  in  1  current instruction is J/JAL/JR.
- `is_branch`  in  1  current instruction is a conditional branch.
- `branch_taken`  in  1  branch condition true; valid only when `is_branch`=1.
- `cpu_en`  out  1  architectural update enable for this cycle (combinational).
- `halted`  out  1  core stopped by halt syscall (registered).
- `total_cycle`  out  32  count of retired instructions.
- `unconditional`  out  CNT_W  count of retired jumps.
- `conditional`  out  CNT_W  count of retired branches.
- `conditionalsucces`  out  CNT_W  count of retired taken branches.
- `syscall_out`  out  32  last `$a0` value latched by a display syscall.

## Operation
- Edge detect: `go_q <= go` every cycle; `go_rise = go & ~go_q`. `go_q` resets to 1, so a button held through reset gives no start.
- Halt condition: `hc = syscall & (v0 == HALT_CODE)`.
- States:
  - IDLE: `go_rise` moves to STEP if `step_mode`=1, else to RUN. No instruction executes on that cycle.
  - RUN: `fire = 1`.
    - `hc` moves to HALT.
    - Otherwise, `step_mode`=1 moves to STEP, with this cycle still firing.
  - STEP: `fire = go_rise & step_mode`.
    - `go_rise & ~step_mode` moves to RUN and does not fire that cycle.
    - `fire & hc` moves to HALT.
  - HALT: sticky until `rst`=0. `go` is ignored. `halted`=1.
- `cpu_en = fire & ~hc` (Mealy). The halting syscall never retires, so PC stays on it and it is not counted.
- On each cycle with `cpu_en`=1, all updates land at the next edge:
  - `total_cycle` +1.
  - `unconditional` +1 if `is_jump`.
  - `conditional` +1 if `is_branch`.
  - `conditionalsucces` +1 if `is_branch & branch_taken`.
  - `syscall_out <= a0` if `syscall & (v0 == SHOW_CODE)`.
- Any other syscall code is a no-op that retires normally.
- All counters are unsigned and wrap modulo 2^width with no saturation.
- `is_jump` and `is_branch` are never both 1. If they are, both counters increment.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `go_q`=1, `halted`=0, all counters 0, `syscall_out`=0. `cpu_en`=0 while in IDLE.
- Reset mid-run takes priority over every other event at the same edge. The core stops at that edge.
- `cpu_en` has zero latency from `state`, `go_rise`, `syscall` and `v0`. It must settle within the cycle, before the PC/RegisterFile/DataMemo edge.
- Counter and `syscall_out` updates are visible one cycle after the enabled cycle.
- `halted` rises one cycle after the cycle where `hc` was seen with `fire`=1.
- One `go` press (rise, hold N cycles, fall) in STEP gives exactly one `cpu_en` pulse, one cycle wide, on the rise cycle.
- When `step_mode` rises during RUN, the instruction in the same cycle still executes. Subsequent cycles require `go_rise`.

## Test plan
- Reset release with `go` held at 1 → state stays IDLE, `cpu_en`=0, all outputs 0. Drop then raise `go` → RUN entered; `cpu_en`=1 from the following cycle.
- RUN for 100 cycles with no syscall → `total_cycle`=100. In the same run, 20 jumps, 30 branches and 12 taken branches → `unconditional`=20, `conditional`=30, `conditionalsucces`=12.
- Syscall with `v0`=34, `a0`=32'hDEADBEEF → `cpu_en`=1, `syscall_out`=32'hDEADBEEF next cycle. Then syscall with `v0`=10 → `cpu_en`=0 that cycle, `halted`=1 next cycle, `total_cycle` frozen. Further `go` pulses change nothing.
- Step mode: 3 `go` presses, each held 5 cycles → exactly 3 single-cycle `cpu_en` pulses, `total_cycle`=3. Clear `step_mode`, then press `go` → RUN with no execution on the press cycle.
- Preload `unconditional`=16'hFFFF via 65535 jumps, then one more jump → wraps to 0. Assert `rst`=0 mid-RUN → all counters 0 and IDLE at the next edge.
